// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM state encoding and the next-PC select codes.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // redirect_sel codes double as the control of the next-PC multiplexor
  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_EXC    = 2'b11;

endpackage

// File: rtl/instruction_fetch_mux.sv
// Four-input multiplexor used to pick the next PC:
// sequential, branch, jump or exception vector.
module multiplexor_4x1
  import instruction_fetch_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [1:0]           control,
  input  logic [BIT_WIDTH-1:0] in0,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  input  logic [BIT_WIDTH-1:0] in3,
  output logic [BIT_WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (control)
      SEL_SEQ:    out = in0;
      SEL_BRANCH: out = in1;
      SEL_JUMP:   out = in2;
      SEL_EXC:    out = in3;
      default:    out = in0;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction memory request at a time
// and hands each instruction/PC pair to decode over a valid/ready handshake.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                   BIT_WIDTH  = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [BIT_WIDTH-1:0] EXC_VECTOR = BIT_WIDTH'(32'h0000_0080)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [1:0]           redirect_sel,
  input  logic [BIT_WIDTH-1:0] redirect_target,
  output logic                 imem_req,
  output logic [BIT_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BIT_WIDTH-1:0] imem_rdata,
  output logic                 dec_valid,
  output logic [BIT_WIDTH-1:0] dec_instr,
  output logic [BIT_WIDTH-1:0] dec_pc,
  input  logic                 dec_ready
);

  localparam logic [BIT_WIDTH-1:0] PC_STEP    = BIT_WIDTH'(4);
  localparam logic [BIT_WIDTH-1:0] ALIGN_MASK = ~BIT_WIDTH'(3);

  fetch_state_t         state, state_next;
  logic [BIT_WIDTH-1:0] pc, pc_next, pc_plus4, target_aligned, next_pc_sel;
  logic                 flush_pending;
  logic                 redirect_active;
  logic [1:0]           npc_control;

  logic pc_load, pc_from_flush, dec_load, dec_clear, flush_set, flush_clear;

  // A select of 00 is a no-op even when redirect_valid is high
  assign redirect_active = redirect_valid && (redirect_sel != SEL_SEQ);
  assign npc_control     = redirect_active ? redirect_sel : SEL_SEQ;
  assign pc_plus4        = pc + PC_STEP;
  assign target_aligned  = redirect_target & ALIGN_MASK;

  multiplexor_4x1 #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_next_pc (
    .control(npc_control),
    .in0    (pc_plus4),
    .in1    (target_aligned),
    .in2    (target_aligned),
    .in3    (EXC_VECTOR),
    .out    (next_pc_sel)
  );

  // The address only moves when pc does, which happens on ack or outside FETCH
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= START;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    imem_req      = 1'b0;
    pc_load       = 1'b0;
    pc_from_flush = 1'b0;
    dec_load      = 1'b0;
    dec_clear     = 1'b0;
    flush_set     = 1'b0;
    flush_clear   = 1'b0;
    case (state)
      START: begin
        state_next = FETCH;
        pc_load    = redirect_active;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          flush_clear = 1'b1;
          pc_load     = 1'b1;
          // A redirect in the ack cycle beats any earlier pending target
          if (redirect_active) begin
            pc_from_flush = 1'b0;
          end else if (flush_pending) begin
            pc_from_flush = 1'b1;
          end else begin
            dec_load   = 1'b1;
            state_next = HOLD;
          end
        end else if (redirect_active) begin
          flush_set = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_active) begin
          pc_load    = 1'b1;
          dec_clear  = 1'b1;
          state_next = FETCH;
        end else if (dec_ready) begin
          dec_clear  = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      pc_next       <= RESET_PC;
      flush_pending <= 1'b0;
      dec_valid     <= 1'b0;
      dec_instr     <= '0;
      dec_pc        <= '0;
    end else begin
      if (pc_load) pc <= pc_from_flush ? pc_next : next_pc_sel;

      if (flush_set) begin
        flush_pending <= 1'b1;
        pc_next       <= next_pc_sel;
      end else if (flush_clear) begin
        flush_pending <= 1'b0;
      end

      if (dec_load) begin
        dec_valid <= 1'b1;
        dec_instr <= imem_rdata;
        dec_pc    <= pc;
      end else if (dec_clear) begin
        dec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a cycle table for the main flow,
// then hand-written reset sequences.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(
    .BIT_WIDTH (32),
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rv;
    logic [1:0]  rsel;
    logic [31:0] rtgt;
    logic        ready;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                             input logic exp_dv, input logic [31:0] exp_pc);
    checkVal({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) checkVal({tag, ".imem_addr"}, imem_addr, exp_addr);
    checkVal({tag, ".dec_valid"}, {31'b0, dec_valid}, {31'b0, exp_dv});
    if (exp_dv) begin
      checkVal({tag, ".dec_pc"}, dec_pc, exp_pc);
      checkVal({tag, ".dec_instr"}, dec_instr, mem_word(exp_pc));
    end
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, ".imem_req"}, {31'b0, imem_req}, 32'd0);
    checkVal({tag, ".imem_addr"}, imem_addr, 32'h0000_0000);
    checkVal({tag, ".dec_valid"}, {31'b0, dec_valid}, 32'd0);
    checkVal({tag, ".dec_pc"}, dec_pc, 32'd0);
    checkVal({tag, ".dec_instr"}, dec_instr, 32'd0);
  endtask

  task automatic applyStimulus(input logic rv, input logic [1:0] rsel, input logic [31:0] rtgt,
                               input logic ready, input logic ack);
    redirect_valid  = rv;
    redirect_sel    = rsel;
    redirect_target = rtgt;
    dec_ready       = ready;
    imem_ack        = ack;
    imem_rdata      = ack ? mem_word(imem_addr) : 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rv, input logic [1:0] rsel, input logic [31:0] rtgt,
                        input logic ready, input logic ack, input logic exp_req,
                        input logic [31:0] exp_addr, input logic exp_dv, input logic [31:0] exp_pc);
    vec_t v;
    v.rv = rv; v.rsel = rsel; v.rtgt = rtgt; v.ready = ready; v.ack = ack;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_dv = exp_dv; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs for the cycle, then outputs expected during that cycle
    addVec(0, SEL_SEQ,    32'h0,         0, 0,  0, 32'h0,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h0,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         1, 0,  0, 32'h0,         1, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h4,         0, 32'h0);
    for (int i = 0; i < 5; i++)
      addVec(0, SEL_SEQ,  32'h0,         0, 0,  0, 32'h0,         1, 32'h4);
    addVec(0, SEL_SEQ,    32'h0,         1, 0,  0, 32'h0,         1, 32'h4);
    addVec(1, SEL_BRANCH, 32'h100,       0, 0,  1, 32'h8,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 0,  1, 32'h8,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h8,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h100,       0, 32'h0);
    addVec(1, SEL_EXC,    32'h0,         0, 0,  0, 32'h0,         1, 32'h100);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h80,        0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         1, 0,  0, 32'h0,         1, 32'h80);
    addVec(1, SEL_JUMP,   32'hFFFF_FFFC, 0, 1,  1, 32'h84,        0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'hFFFF_FFFC, 0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         1, 0,  0, 32'h0,         1, 32'hFFFF_FFFC);
    addVec(1, SEL_BRANCH, 32'h103,       0, 0,  1, 32'h0,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h0,         0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h100,       0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         1, 0,  0, 32'h0,         1, 32'h100);
    addVec(1, SEL_BRANCH, 32'h200,       0, 0,  1, 32'h104,       0, 32'h0);
    addVec(1, SEL_JUMP,   32'h300,       0, 0,  1, 32'h104,       0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h104,       0, 32'h0);
    addVec(1, SEL_SEQ,    32'h500,       0, 0,  1, 32'h300,       0, 32'h0);
    addVec(0, SEL_SEQ,    32'h0,         0, 1,  1, 32'h300,       0, 32'h0);
    addVec(1, SEL_BRANCH, 32'h40,        1, 0,  0, 32'h0,         1, 32'h300);
    addVec(0, SEL_SEQ,    32'h0,         0, 0,  1, 32'h40,        0, 32'h0);

    rst_n = 1'b0;
    applyStimulus(0, SEL_SEQ, 32'h0, 0, 0);
    tick();
    tick();
    checkReset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_dv, vecs[i].exp_pc);
      applyStimulus(vecs[i].rv, vecs[i].rsel, vecs[i].rtgt, vecs[i].ready, vecs[i].ack);
      tick();
    end

    // Reset pulsed mid-request, away from any clock edge
    checkOutput("pre_rst", 1'b1, 32'h40, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("start_stale", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(0, SEL_SEQ, 32'h0, 0, 1);
    tick();
    checkOutput("after_stale", 1'b1, 32'h0, 1'b0, 32'h0);
    applyStimulus(0, SEL_SEQ, 32'h0, 0, 1);
    tick();
    checkOutput("first_fetch", 1'b0, 32'h0, 1'b1, 32'h0);
    applyStimulus(0, SEL_SEQ, 32'h0, 1, 0);
    tick();
    checkOutput("second_req", 1'b1, 32'h4, 1'b0, 32'h0);

    // Redirect while still in START
    rst_n = 1'b0;
    applyStimulus(0, SEL_SEQ, 32'h0, 0, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1, SEL_JUMP, 32'h26, 0, 0);
    tick();
    applyStimulus(0, SEL_SEQ, 32'h0, 0, 0);
    checkOutput("start_redirect", 1'b1, 32'h24, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
